// File: rtl/lpfull_inject_ctrl_pkg.sv
// Shared types, full-scale constants and pattern helpers for the lowpass-filter
// injection sequencer.
package lpfull_pkg;

    localparam int NSAMP = 8;
    localparam int NBITS = 12;

    typedef logic signed [NBITS-1:0] sample_t;
    typedef logic [NSAMP*NBITS-1:0]  lanes_t;

    typedef enum logic [1:0] {
        MODE_IMPULSE   = 2'd0,
        MODE_BURST_NEG = 2'd1,
        MODE_BURST_POS = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREZ  = 3'd1,
        INJ   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam sample_t FS_POS = sample_t'(2**(NBITS-1) - 1);
    localparam sample_t FS_NEG = sample_t'(-(2**(NBITS-1)));

    // Code 3 is reserved and behaves as an impulse.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'd1:    m = MODE_BURST_NEG;
            2'd2:    m = MODE_BURST_POS;
            default: m = MODE_IMPULSE;
        endcase
        return m;
    endfunction

    // Counter width large enough for the longest of the three phases, plus headroom.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

    // Even lanes alternate full-scale; phase flips the whole pattern each burst clock.
    function automatic lanes_t inject_pattern(input mode_e mode, input sample_t amp,
                                              input logic phase);
        lanes_t p;
        logic   neg;
        p   = '0;
        neg = 1'b0;
        if (mode == MODE_IMPULSE) begin
            p[NBITS-1:0] = amp;
        end else begin
            for (int k = 0; k < NSAMP; k += 2) begin
                neg = (((k / 2) % 2) == 0) ^ (mode == MODE_BURST_POS) ^ phase;
                p[NBITS*k +: NBITS] = neg ? FS_NEG : FS_POS;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/lpfull_inject_ctrl_if.sv
// Sample, command and status bundle between the injection sequencer (slave)
// and its environment (master).
interface lpfull_inject_ctrl_if #(
    parameter int LENW = 5
);
    import lpfull_pkg::*;

    lanes_t          live_i;
    logic            start_i;
    logic            abort_i;
    logic [1:0]      mode_i;
    sample_t         amp_i;
    logic [LENW-1:0] burst_len_i;
    lanes_t          filt_in_o;
    lanes_t          filt_out_i;
    logic            busy_o;
    logic            done_o;
    sample_t         peak_o;
    sample_t         min_o;

    modport slave (
        input  live_i, start_i, abort_i, mode_i, amp_i, burst_len_i, filt_out_i,
        output filt_in_o, busy_o, done_o, peak_o, min_o
    );

    modport master (
        output live_i, start_i, abort_i, mode_i, amp_i, burst_len_i, filt_out_i,
        input  filt_in_o, busy_o, done_o, peak_o, min_o
    );

endinterface

// File: rtl/lpfull_minmax_tree.sv
// Signed max/min reduction over all lanes of one clock of filter output,
// registered once; vld_o marks which registered results belong to the window.
module lpfull_minmax_tree
    import lpfull_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    vld_i,
    input  lanes_t  data_i,
    output logic    vld_o,
    output sample_t max_o,
    output sample_t min_o
);

    sample_t max_d, max_q;
    sample_t min_d, min_q;
    sample_t lane;
    logic    vld_d, vld_q;

    always_comb begin
        vld_d = vld_i;
        lane  = sample_t'(data_i[NBITS-1:0]);
        max_d = lane;
        min_d = lane;
        for (int k = 1; k < NSAMP; k++) begin
            lane = sample_t'(data_i[NBITS*k +: NBITS]);
            if (lane > max_d) max_d = lane;
            if (lane < min_d) min_d = lane;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_q <= 1'b0;
            max_q <= '0;
            min_q <= '0;
        end else begin
            vld_q <= vld_d;
            max_q <= max_d;
            min_q <= min_d;
        end
    end

    assign vld_o = vld_q;
    assign max_o = max_q;
    assign min_o = min_q;

endmodule

// File: rtl/lpfull_inject_ctrl.sv
// Test-pattern sequencer in front of the lowpass filter: live pass-through, pre-flush,
// impulse/burst injection, post-flush. Define LPFULL_INJECT_CAPTURE_EN for peak/min capture.
module lpfull_inject_ctrl
    import lpfull_pkg::*;
#(
    parameter int PRE_ZERO = 4,
    parameter int LATENCY  = 16,
    parameter int LENW     = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    lpfull_inject_ctrl_if.slave  bus
);

    localparam int CNT_W = cnt_width(PRE_ZERO, LATENCY, 2**LENW);
    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_ZERO - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    mode_e            mode_d, mode_q;
    sample_t          amp_d, amp_q;
    logic [LENW-1:0]  len_d, len_q;
    logic             phase_d, phase_q;
    lanes_t           filt_in_d, filt_in_q;
    logic             arm;
    logic             running;

    assign running = (state_q == PREZ) || (state_q == INJ) || (state_q == FLUSH);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        amp_d     = amp_q;
        len_d     = len_q;
        phase_d   = phase_q;
        filt_in_d = '0;
        arm       = 1'b0;

        case (state_q)
            IDLE: begin
                filt_in_d = bus.live_i;
                if (bus.start_i) begin
                    arm     = 1'b1;
                    mode_d  = decode_mode(bus.mode_i);
                    amp_d   = bus.amp_i;
                    len_d   = (bus.burst_len_i == '0) ? LENW'(1) : bus.burst_len_i;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    state_d = PREZ;
                end
            end
            PREZ: begin
                if (cnt_q == PRE_LAST) begin
                    cnt_d   = '0;
                    state_d = INJ;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            INJ: begin
                filt_in_d = inject_pattern(mode_q, amp_q, phase_q);
                phase_d   = ~phase_q;
                if ((mode_q == MODE_IMPULSE) || ((cnt_q + CNT_ONE) == CNT_W'(len_q))) begin
                    cnt_d   = '0;
                    state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                filt_in_d = bus.live_i;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides whatever advance the running phase computed.
        if (bus.abort_i && running) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mode_q    <= MODE_IMPULSE;
            amp_q     <= '0;
            len_q     <= '0;
            phase_q   <= 1'b0;
            filt_in_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            amp_q     <= amp_d;
            len_q     <= len_d;
            phase_q   <= phase_d;
            filt_in_q <= filt_in_d;
        end
    end

    assign bus.filt_in_o = filt_in_q;
    assign bus.busy_o    = running;
    assign bus.done_o    = (state_q == DONE);

`ifdef LPFULL_INJECT_CAPTURE_EN
    sample_t peak_d, peak_q;
    sample_t min_d, min_q;
    sample_t tree_max, tree_min;
    logic    tree_vld;
    logic    win;

    assign win = (state_q == INJ) || (state_q == FLUSH);

    lpfull_minmax_tree u_tree (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .vld_i  (win),
        .data_i (bus.filt_out_i),
        .vld_o  (tree_vld),
        .max_o  (tree_max),
        .min_o  (tree_min)
    );

    // A fresh run re-seeds the extremes; otherwise fold in the registered tree result.
    always_comb begin
        peak_d = peak_q;
        min_d  = min_q;
        if (arm) begin
            peak_d = FS_NEG;
            min_d  = FS_POS;
        end else if (tree_vld) begin
            if (tree_max > peak_q) peak_d = tree_max;
            if (tree_min < min_q)  min_d  = tree_min;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            peak_q <= '0;
            min_q  <= '0;
        end else begin
            peak_q <= peak_d;
            min_q  <= min_d;
        end
    end

    assign bus.peak_o = peak_q;
    assign bus.min_o  = min_q;
`else
    assign bus.peak_o = '0;
    assign bus.min_o  = '0;
`endif

endmodule

// File: tb/tb_lpfull_inject_ctrl.sv
// Directed bench for lpfull_inject_ctrl with an echo filter (output equals input).
// Expected peak/min follow LPFULL_INJECT_CAPTURE_EN.
module tb_lpfull_inject_ctrl;
    import lpfull_pkg::*;

`ifdef LPFULL_INJECT_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk_i = ~clk_i;

    lpfull_inject_ctrl_if #(.LENW(5)) bus ();

    lpfull_inject_ctrl #(.PRE_ZERO(4), .LATENCY(16), .LENW(5)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    assign bus.filt_out_i = bus.filt_in_o;

    function automatic lanes_t pack8(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
        lanes_t b;
        int     v[8];
        v = '{a0, a1, a2, a3, a4, a5, a6, a7};
        b = '0;
        for (int k = 0; k < 8; k++) b[NBITS*k +: NBITS] = sample_t'(v[k]);
        return b;
    endfunction

    function automatic sample_t cap(input int v);
        return CAP ? sample_t'(v) : sample_t'(0);
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    lanes_t live1, live2, b_neg, b_pos, zero;

    // Starts a run, then checks filt_in/done/busy every clock up to DONE and the capture after.
    task automatic run_seq(input string tag, input logic [1:0] mode, input sample_t amp,
                           input logic [4:0] len, input int inj_clks,
                           input lanes_t p0, input lanes_t p1, input bit noise,
                           input bit with_abort, input sample_t exp_pk, input sample_t exp_mn);
        lanes_t exp_fi;
        bus.mode_i      = mode;
        bus.amp_i       = amp;
        bus.burst_len_i = len;
        bus.start_i     = 1'b1;
        bus.abort_i     = with_abort;
        tick();
        check({tag, "_busy0"}, bus.busy_o, 1'b1);
        bus.start_i     = 1'b0;
        bus.abort_i     = 1'b0;
        bus.mode_i      = 2'd3;
        bus.amp_i       = sample_t'(77);
        bus.burst_len_i = 5'd9;
        for (int e = 1; e <= 20 + inj_clks; e++) begin
            tick();
            if (e >= 5 && e < 5 + inj_clks) exp_fi = (((e - 5) % 2) == 0) ? p0 : p1;
            else                            exp_fi = zero;
            check({tag, "_fi"},   bus.filt_in_o, exp_fi);
            check({tag, "_done"}, bus.done_o, (e == 20 + inj_clks));
            check({tag, "_busy"}, bus.busy_o, (e < 20 + inj_clks));
            bus.start_i = noise && (e >= 2) && (e <= 10);
        end
        tick();
        check({tag, "_live"},  bus.filt_in_o, live2);
        check({tag, "_done1"}, bus.done_o, 1'b0);
        check({tag, "_peak"},  bus.peak_o, exp_pk);
        check({tag, "_min"},   bus.min_o, exp_mn);
    endtask

    initial begin
        bit seen_done;
        live1 = pack8(100, 0, 0, 0, 0, 0, 0, 0);
        live2 = pack8(1000, -1000, 3, -3, 500, -500, 7, -7);
        b_neg = pack8(-2048, 0, 2047, 0, -2048, 0, 2047, 0);
        b_pos = pack8(2047, 0, -2048, 0, 2047, 0, -2048, 0);
        zero  = '0;

        bus.live_i      = live1;
        bus.start_i     = 1'b0;
        bus.abort_i     = 1'b0;
        bus.mode_i      = 2'd0;
        bus.amp_i       = '0;
        bus.burst_len_i = '0;

        #12;
        check("rst_fi",   bus.filt_in_o, zero);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_done", bus.done_o, 1'b0);
        check("rst_peak", bus.peak_o, sample_t'(0));
        check("rst_min",  bus.min_o, sample_t'(0));
        #1 rst_i = 1'b1;

        tick();
        check("live1_fi",   bus.filt_in_o, live1);
        check("live1_busy", bus.busy_o, 1'b0);
        bus.live_i = live2;
        tick();
        check("live2_fi", bus.filt_in_o, live2);

        run_seq("imp", 2'd0, sample_t'(100), 5'd0, 1,
                pack8(100, 0, 0, 0, 0, 0, 0, 0), zero, 1'b0, 1'b0, cap(100), cap(0));
        run_seq("burst", 2'd1, sample_t'(0), 5'd2, 2,
                b_neg, b_pos, 1'b1, 1'b0, cap(2047), cap(-2048));
        run_seq("len0", 2'd2, sample_t'(0), 5'd0, 1,
                b_pos, b_neg, 1'b0, 1'b1, cap(2047), cap(-2048));
        run_seq("rsv", 2'd3, sample_t'(-300), 5'd4, 1,
                pack8(-300, 0, 0, 0, 0, 0, 0, 0), zero, 1'b0, 1'b0, cap(0), cap(-300));

        // Abort on the second FLUSH clock of an impulse run.
        bus.mode_i      = 2'd0;
        bus.amp_i       = sample_t'(50);
        bus.burst_len_i = 5'd0;
        bus.start_i     = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        check("abort_busy_pre", bus.busy_o, 1'b1);
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        check("abort_busy", bus.busy_o, 1'b0);
        check("abort_done", bus.done_o, 1'b0);
        check("abort_fi",   bus.filt_in_o, zero);
        tick();
        check("abort_live", bus.filt_in_o, live2);
        check("abort_peak", bus.peak_o, cap(50));
        check("abort_min",  bus.min_o, cap(0));
        seen_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.done_o) seen_done = 1'b1;
        end
        check("abort_nodone", seen_done, 1'b0);

        // Asynchronous reset in the middle of a burst injection.
        bus.mode_i      = 2'd1;
        bus.burst_len_i = 5'd4;
        bus.start_i     = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int e = 1; e <= 5; e++) tick();
        check("arst_pre_fi", bus.filt_in_o, b_neg);
        rst_i = 1'b0;
        #1;
        check("arst_fi",   bus.filt_in_o, zero);
        check("arst_busy", bus.busy_o, 1'b0);
        check("arst_done", bus.done_o, 1'b0);
        check("arst_peak", bus.peak_o, sample_t'(0));
        check("arst_min",  bus.min_o, sample_t'(0));
        #2 rst_i = 1'b1;
        tick();
        check("arst_live",  bus.filt_in_o, live2);
        check("arst_busy1", bus.busy_o, 1'b0);
        tick();
        check("arst_busy2", bus.busy_o, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
